alu_secuenciador: RTL and testbench

ALU_SECUENCIADOR -- requirements
Module: alu_secuenciador

---
 rtl/alu_secuenciador.sv | 83 ++++++++
 tb/tb_alu_secuenciador.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/alu_secuenciador.sv
// alu_secuenciador: three-state sequencer feeding an external ALU and registering its result
module alu_secuenciador #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_A,
  input  logic [3:0]       in_B,
  input  logic [1:0]       in_op,
  output logic [1:0]       alu_A,
  output logic [3:0]       alu_B,
  output logic [1:0]       alu_op,
  input  logic [3:0]       alu_Y,
  input  logic             alu_Z,
  input  logic             alu_N,
  input  logic             alu_C,
  input  logic             alu_V,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       res_Y,
  output logic             res_Z,
  output logic             res_N,
  output logic             res_C,
  output logic             res_V,
  output logic             sticky_C,
  output logic             sticky_V,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t state;

  // Sequencer: accept operands, capture ALU result after one EXEC cycle, hold until taken downstream
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      alu_A     <= '0;
      alu_B     <= '0;
      alu_op    <= '0;
      res_Y     <= '0;
      {res_Z, res_N, res_C, res_V} <= '0;
      sticky_C  <= 1'b0;
      sticky_V  <= 1'b0;
      op_count  <= '0;
    end else begin
      sticky_C <= clr_sticky ? 1'b0 : sticky_C | (state == EXEC && alu_C);
      sticky_V <= clr_sticky ? 1'b0 : sticky_V | (state == EXEC && alu_V);
      case (state)
        IDLE: if (in_valid) begin
          alu_A    <= in_A;
          alu_B    <= in_B;
          alu_op   <= in_op;
          in_ready <= 1'b0;
          state    <= EXEC;
        end
        EXEC: begin
          res_Y     <= alu_Y;
          {res_Z, res_N, res_C, res_V} <= {alu_Z, alu_N, alu_C, alu_V};
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          op_count  <= (op_count == '1) ? op_count : op_count + 1'b1;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_secuenciador.sv
// tb_alu_secuenciador: directed scoreboard bench for alu_secuenciador (counter width 2 to reach saturation)
module tb_alu_secuenciador;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, out_valid, out_ready, clr_sticky;
  logic [1:0]    in_A, in_op, alu_A, alu_op;
  logic [3:0]    in_B, alu_B, alu_Y, res_Y;
  logic          alu_Z, alu_N, alu_C, alu_V;
  logic          res_Z, res_N, res_C, res_V, sticky_C, sticky_V;
  logic [CW-1:0] op_count;

  int n_cmp = 0;
  int n_err = 0;
  int cnt = 0;
  logic sc = 1'b0;
  logic sv = 1'b0;
  logic [7:0] exp_q[$];

  alu_secuenciador #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_A(in_A), .in_B(in_B), .in_op(in_op),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
    .alu_Y(alu_Y), .alu_Z(alu_Z), .alu_N(alu_N), .alu_C(alu_C), .alu_V(alu_V),
    .out_valid(out_valid), .out_ready(out_ready),
    .res_Y(res_Y), .res_Z(res_Z), .res_N(res_N), .res_C(res_C), .res_V(res_V),
    .sticky_C(sticky_C), .sticky_V(sticky_V), .clr_sticky(clr_sticky), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [1:0] a, input logic [3:0] b, input logic [1:0] op,
                       input logic [3:0] y, input logic z, input logic n, input logic c,
                       input logic v, input bit clr, input int hold);
    logic [7:0] exp;
    chk("idle_in_ready", in_ready, 1);
    in_A = a; in_B = b; in_op = op; in_valid = 1'b1;
    alu_Y = y; alu_Z = z; alu_N = n; alu_C = c; alu_V = v;
    exp_q.push_back({y, z, n, c, v});
    tick;
    chk("exec_in_ready", in_ready, 0);
    chk("exec_out_valid", out_valid, 0);
    chk("exec_alu_ops", {alu_A, alu_B, alu_op}, {a, b, op});
    in_valid = 1'b0; in_A = ~a; in_B = ~b; in_op = ~op;
    clr_sticky = clr; out_ready = 1'b1;
    tick;
    sc = clr ? 1'b0 : sc | c;
    sv = clr ? 1'b0 : sv | v;
    clr_sticky = 1'b0;
    chk("done_out_valid", out_valid, 1);
    chk("done_in_ready", in_ready, 0);
    if (exp_q.size() == 0) begin
      exp = 8'hxx;
      chk("scoreboard_empty", 1, 0);
    end else exp = exp_q.pop_front();
    chk("done_result", {res_Y, res_Z, res_N, res_C, res_V}, exp);
    chk("done_sticky", {sticky_C, sticky_V}, {sc, sv});
    if (hold > 0) begin
      out_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        in_valid = ~in_valid;
        in_A = 2'($urandom); in_B = 4'($urandom); in_op = 2'($urandom);
        alu_Y = ~y;
        tick;
        chk("hold_result", {res_Y, res_Z, res_N, res_C, res_V}, exp);
        chk("hold_flow", {in_ready, out_valid}, 2'b01);
        chk("hold_alu_ops", {alu_A, alu_B, alu_op}, {a, b, op});
        chk("hold_count", op_count, cnt);
      end
      out_ready = 1'b1;
      in_valid = 1'b1;
    end
    tick;
    cnt = (cnt == (1 << CW) - 1) ? cnt : cnt + 1;
    chk("ret_flow", {in_ready, out_valid}, 2'b10);
    chk("ret_count", op_count, cnt);
    chk("ret_alu_ops", {alu_A, alu_B, alu_op}, {a, b, op});
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic reset_all;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    sc = 1'b0; sv = 1'b0; cnt = 0;
    exp_q.delete();
    chk("rst_flow", {in_ready, out_valid}, 2'b10);
    chk("rst_result", {res_Y, res_Z, res_N, res_C, res_V}, 0);
    chk("rst_alu_ops", {alu_A, alu_B, alu_op}, 0);
    chk("rst_sticky", {sticky_C, sticky_V}, 0);
    chk("rst_count", op_count, 0);
  endtask

  task automatic abort(input int stage);
    in_A = 2'b11; in_B = 4'b0111; in_op = 2'b10; in_valid = 1'b1;
    alu_Y = 4'b0101; alu_Z = 1'b0; alu_N = 1'b0; alu_C = 1'b1; alu_V = 1'b1;
    tick;
    in_valid = 1'b0; out_ready = 1'b1;
    if (stage == 2) begin
      out_ready = 1'b0;
      tick;
      chk("abort_done_valid", out_valid, 1);
      out_ready = 1'b1;
    end
    reset_all;
    out_ready = 1'b0;
    tick;
    chk("abort_idle_flow", {in_ready, out_valid}, 2'b10);
    chk("abort_idle_count", op_count, 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
    in_A = '0; in_B = '0; in_op = '0;
    alu_Y = '0; alu_Z = 1'b0; alu_N = 1'b0; alu_C = 1'b0; alu_V = 1'b0;
    tick;
    reset_all;
    do_op(2'b10, 4'b1101, 2'b00, 4'b0000, 1, 0, 0, 0, 0, 0);
    do_op(2'b01, 4'b1000, 2'b11, 4'b1001, 0, 1, 1, 0, 0, 0);
    do_op(2'b11, 4'b0101, 2'b01, 4'b0110, 0, 0, 0, 0, 0, 0);
    do_op(2'b10, 4'b0011, 2'b10, 4'b0110, 0, 0, 0, 0, 0, 5);
    do_op(2'b11, 4'b0101, 2'b10, 4'b1111, 0, 1, 0, 1, 1, 0);
    do_op(2'b00, 4'b0001, 2'b11, 4'b1111, 0, 1, 1, 1, 0, 0);
    abort(1);
    do_op(2'b01, 4'b0010, 2'b00, 4'b0000, 1, 0, 0, 0, 0, 0);
    abort(2);
    for (int i = 0; i < 5; i++)
      do_op(2'(i), 4'(i + 3), 2'(i), 4'(i * 3), 0, 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
